sha256_block_padder: RTL and testbench
======================================

Name: sha256_block_padder

Overview:
- Upstream feeder stage for the SHA-256 compression engine.
- Reads a NUM_OF_WORDS-word message from word-addressed memory starting at input_addr.
- Applies standard SHA-256 padding: 0x80000000 marker word, zero fill, then the 64-bit big-endian bit length.
- Presents the result as whole 512-bit blocks over a valid/ready handshake, so the compression core never touches memory reads or padding logic.

Parameters:
- NUM_OF_WORDS, 40, message length in 32-bit words; legal range 1..1024.
- NUM_BLOCKS, ceil((NUM_OF_WORDS+3)/16), derived, not overridable; number of 512-bit blocks emitted.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin processing; sampled only in IDLE.
- input_addr  input  16  word address of message word 0; captured on the accepted start.
- memory_addr  output  16  read address to message memory.
- memory_read_data  input  32  read data; valid one cycle after its address is driven.
- block_data  output  512  padded block; word 0 in [511:480], word 15 in [31:0].
- block_valid  output  1  block_data holds a complete block.
- block_ready  input  1  consumer accepts the block.
- block_last  output  1  qualifies block_valid; high on the final block only.
- block_index  output  8  0-based index of the presented block.
- done  output  1  high whenever the block is in IDLE.

Behaviour:
- Reset values (async, while rst_n=0): state=IDLE, block_valid=0, block_last=0, block_index=0, block_data=0, memory_addr=0, done=1, all internal counters=0. Reset asserted mid-operation aborts immediately. No block is emitted until a new start.
- States are IDLE, FILL, PRESENT.
- IDLE:
  - start=1 captures input_addr into base, clears msg_idx and blk_idx, and moves to FILL.
  - done=0 from the next cycle.
- FILL: exactly 17 cycles per block.
  - Cycle 0 is address-only.
  - Cycles 1..16 write slots 0..15, one per cycle.
  - memory_addr = base + msg_idx. msg_idx increments each cycle a message word is requested, until it reaches NUM_OF_WORDS. After that memory_addr holds its last value.
  - Slot content, with g = blk_idx*16 + slot:
    - g < NUM_OF_WORDS: memory_read_data.
    - g == NUM_OF_WORDS: 32'h80000000.
    - slot 14 of the final block: 32'h00000000 (upper length word; always 0 in the legal range).
    - slot 15 of the final block: 32*NUM_OF_WORDS.
    - all others: 0.
  - At the end of cycle 16, move to PRESENT.
  - block_valid therefore rises 17 cycles after the start-accepting edge, and 17 cycles after each prior transfer.
- PRESENT:
  - block_valid=1, block_last=(blk_idx==NUM_BLOCKS-1), block_index=blk_idx.
  - block_data, block_last and block_index stay stable while block_ready=0. No memory address change and no counter movement during stall.
  - Transfer occurs on a cycle with block_valid & block_ready.
  - Not last block: blk_idx++, go to FILL. block_valid=0 the next cycle.
  - Last block: go to IDLE. done=1 and block_valid=0 the next cycle.
- The final-block padding test uses NUM_BLOCKS, so these cases need no special handling:
  - NUM_OF_WORDS mod 16 in {14,15}: the marker sits in one block and the length in an extra all-zero block.
  - NUM_OF_WORDS mod 16 == 0: the extra block holds only the marker and the length.
- start while not in IDLE is ignored, including in the last-transfer cycle.
- block_ready while block_valid=0 has no effect.
- Address arithmetic is 16-bit and wraps modulo 2^16.

Test Plan:
- NUM_OF_WORDS=40, mem[a+i]=i+1, block_ready=1 → 3 blocks, block_last only on index 2. Block 2 slots 0..7 = 33..40, slot 8=0x80000000, slots 9..14=0, slot 15=0x00000500. memory_addr runs a..a+39.
- NUM_OF_WORDS=14 → 2 blocks. Block 0: slot 14=0x80000000, slot 15=0. Block 1: slots 0..14=0, slot 15=0x000001C0.
- NUM_OF_WORDS=13 → 1 block with block_last=1: slot 13=0x80000000, slot 14=0, slot 15=0x000001A0. First block_valid exactly 17 cycles after the start edge.
- NUM_OF_WORDS=40, block_ready held 0 for 5 cycles on block 0 → block_data/block_index/memory_addr constant throughout. Block 1 appears 17 cycles after the accepting edge.
- rst_n pulsed low in the 8th FILL cycle → outputs at reset values immediately, done=1. A new start reproduces the full correct sequence from block 0.
- start pulsed in PRESENT and in FILL → ignored: block count, contents and input_addr capture unchanged.

Source files
------------

// File: rtl/sha256_block_padder.sv
// SHA-256 message feeder: fetches NUM_OF_WORDS words from memory, applies standard
// padding and hands whole 512-bit blocks to the compression core over valid/ready.
module sha256_block_padder #(
  parameter int NUM_OF_WORDS = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [15:0]  input_addr,
  output logic [15:0]  memory_addr,
  input  logic [31:0]  memory_read_data,
  output logic [511:0] block_data,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         block_last,
  output logic [7:0]   block_index,
  output logic         done
);

  localparam int          NUM_BLOCKS  = (NUM_OF_WORDS + 18) / 16;
  localparam logic [15:0] LP_WORDS    = 16'(NUM_OF_WORDS);
  localparam logic [7:0]  LP_LAST_BLK = 8'(NUM_BLOCKS - 1);
  localparam logic [31:0] LP_BIT_LEN  = 32'(32 * NUM_OF_WORDS);

  typedef enum logic [1:0] {IDLE, FILL, PRESENT} state_t;

  state_t         r_state;
  state_t         w_nextState;
  logic [4:0]     r_cyc;
  logic [15:0]    r_msgIdx;
  logic [15:0]    r_memAddr;
  logic [7:0]     r_blkIdx;
  logic [511:0]   r_blockData;

  logic           w_request;
  logic           w_finalBlk;
  logic [3:0]     w_slot;
  logic [15:0]    w_g;
  logic [31:0]    w_word;
  logic           w_valid;
  logic           w_last;
  logic           w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = FILL;
      FILL:    if (r_cyc == 5'd16) w_nextState = PRESENT;
      PRESENT: if (block_ready) w_nextState = w_finalBlk ? IDLE : FILL;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_valid = (r_state == PRESENT);
    w_last  = (r_state == PRESENT) && w_finalBlk;
    w_done  = (r_state == IDLE);
  end

  // Slot written in FILL cycle c is c-1; its data was addressed in cycle c-1.
  assign w_finalBlk = (r_blkIdx == LP_LAST_BLK);
  assign w_slot     = 4'(r_cyc - 5'd1);
  assign w_g        = {4'b0, r_blkIdx, w_slot};
  assign w_request  = (r_state == FILL) && (r_cyc < 5'd16) && (r_msgIdx < LP_WORDS);

  always_comb begin
    w_word = 32'h0000_0000;
    if (w_g < LP_WORDS)                          w_word = memory_read_data;
    else if (w_g == LP_WORDS)                    w_word = 32'h8000_0000;
    else if (w_finalBlk && (w_slot == 4'd15))    w_word = LP_BIT_LEN;
  end

  // Address register stops at the last message word rather than running past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc       <= 5'd0;
      r_msgIdx    <= 16'd0;
      r_memAddr   <= 16'd0;
      r_blkIdx    <= 8'd0;
      r_blockData <= 512'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_memAddr <= input_addr;
            r_msgIdx  <= 16'd0;
            r_blkIdx  <= 8'd0;
            r_cyc     <= 5'd0;
          end
        end
        FILL: begin
          r_cyc <= (r_cyc == 5'd16) ? 5'd0 : r_cyc + 5'd1;
          if (w_request) begin
            r_msgIdx <= r_msgIdx + 16'd1;
            if ((r_msgIdx + 16'd1) < LP_WORDS) r_memAddr <= r_memAddr + 16'd1;
          end
          if (r_cyc != 5'd0) r_blockData <= {r_blockData[479:0], w_word};
        end
        PRESENT: begin
          if (block_ready && !w_finalBlk) r_blkIdx <= r_blkIdx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign memory_addr = r_memAddr;
  assign block_data  = r_blockData;
  assign block_index = r_blkIdx;
  assign block_valid = w_valid;
  assign block_last  = w_last;
  assign done        = w_done;

endmodule

// File: tb/tb_sha256_block_padder.sv
// Directed bench for sha256_block_padder: three instances (40, 14 and 13 words)
// share one clock and reset; a selector routes the active one to the checks.
module tb_sha256_block_padder;

  logic         clk = 1'b0;
  logic         rstN;
  logic         start;
  logic [15:0]  inputAddr;
  logic         ready;
  int           sel;
  logic [15:0]  baseAddr;

  logic [15:0]  mAddr  [3];
  logic [31:0]  rData  [3];
  logic [511:0] bData  [3];
  logic         bValid [3];
  logic         bLast  [3];
  logic [7:0]   bIndex [3];
  logic         bDone  [3];
  logic         startG [3];

  logic [511:0] gotBlk [4];
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  assign startG[0] = start && (sel == 0);
  assign startG[1] = start && (sel == 1);
  assign startG[2] = start && (sel == 2);

  sha256_block_padder #(.NUM_OF_WORDS(40)) u40 (
    .clk(clk), .rst_n(rstN), .start(startG[0]), .input_addr(inputAddr),
    .memory_addr(mAddr[0]), .memory_read_data(rData[0]), .block_data(bData[0]),
    .block_valid(bValid[0]), .block_ready(ready), .block_last(bLast[0]),
    .block_index(bIndex[0]), .done(bDone[0]));

  sha256_block_padder #(.NUM_OF_WORDS(14)) u14 (
    .clk(clk), .rst_n(rstN), .start(startG[1]), .input_addr(inputAddr),
    .memory_addr(mAddr[1]), .memory_read_data(rData[1]), .block_data(bData[1]),
    .block_valid(bValid[1]), .block_ready(ready), .block_last(bLast[1]),
    .block_index(bIndex[1]), .done(bDone[1]));

  sha256_block_padder #(.NUM_OF_WORDS(13)) u13 (
    .clk(clk), .rst_n(rstN), .start(startG[2]), .input_addr(inputAddr),
    .memory_addr(mAddr[2]), .memory_read_data(rData[2]), .block_data(bData[2]),
    .block_valid(bValid[2]), .block_ready(ready), .block_last(bLast[2]),
    .block_index(bIndex[2]), .done(bDone[2]));

  // Memory holds word i+1 at baseAddr+i, with a one-cycle registered read.
  function automatic logic [31:0] memVal(input logic [15:0] ad);
    logic [15:0] off;
    off = ad - baseAddr;
    return {16'h0000, off} + 32'd1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) rData[i] <= memVal(mAddr[i]);
  end

  function automatic int wordsOf(input int s);
    case (s)
      0:       return 40;
      1:       return 14;
      default: return 13;
    endcase
  endfunction

  function automatic logic [31:0] expWord(input int n, input int b, input int s);
    int g;
    int nb;
    g  = b * 16 + s;
    nb = (n + 18) / 16;
    if (g < n)                      return 32'(g + 1);
    if (g == n)                     return 32'h8000_0000;
    if ((b == nb - 1) && (s == 15)) return 32'(32 * n);
    return 32'h0;
  endfunction

  function automatic logic [511:0] expBlock(input int n, input int b);
    logic [511:0] e;
    e = '0;
    for (int s = 0; s < 16; s++) e[511 - 32 * s -: 32] = expWord(n, b, s);
    return e;
  endfunction

  function automatic logic [31:0] slotOf(input logic [511:0] blk, input int s);
    return blk[511 - 32 * s -: 32];
  endfunction

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkIdle(input string tag, input logic [15:0] expAddr, input logic [511:0] expData);
    checkOutput({tag, "_done"},  512'(bDone[sel]),  512'd1);
    checkOutput({tag, "_valid"}, 512'(bValid[sel]), 512'd0);
    checkOutput({tag, "_last"},  512'(bLast[sel]),  512'd0);
    checkOutput({tag, "_addr"},  512'(mAddr[sel]),  512'(expAddr));
    checkOutput({tag, "_data"},  bData[sel],        expData);
  endtask

  // Runs one whole message; optional start noise throughout and a stall on block 0.
  task automatic applyStimulus(input int s, input logic [15:0] a, input bit noise, input int stall);
    int n;
    int nb;
    int cnt;
    int reached;
    logic [15:0] stallAddr;
    n         = wordsOf(s);
    nb        = (n + 18) / 16;
    sel       = s;
    baseAddr  = a;
    inputAddr = a;
    ready     = (stall == 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (noise) inputAddr = 16'h5555;
    else       start = 1'b0;
    checkOutput("done_low", 512'(bDone[sel]), 512'd0);
    for (int b = 0; b < nb; b++) begin
      cnt = 0;
      do begin
        @(posedge clk);
        cnt++;
        #1;
      end while (!bValid[sel] && cnt < 40);
      checkOutput($sformatf("latency_b%0d", b), 512'(cnt), 512'd17);
      checkOutput($sformatf("data_b%0d", b),  bData[sel],        expBlock(n, b));
      checkOutput($sformatf("index_b%0d", b), 512'(bIndex[sel]), 512'(b));
      checkOutput($sformatf("last_b%0d", b),  512'(bLast[sel]),  512'(b == nb - 1));
      gotBlk[b] = bData[sel];
      if (b == 0 && stall > 0) begin
        reached   = (16 < n) ? 16 : n;
        stallAddr = a + 16'((reached < n) ? reached : n - 1);
        for (int k = 0; k < stall; k++) begin
          @(posedge clk);
          #1;
          checkOutput("stall_valid", 512'(bValid[sel]), 512'd1);
          checkOutput("stall_data",  bData[sel],        expBlock(n, 0));
          checkOutput("stall_index", 512'(bIndex[sel]), 512'd0);
          checkOutput("stall_addr",  512'(mAddr[sel]),  512'(stallAddr));
        end
        ready = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (noise) start = 1'b0;
    checkIdle("end", a + 16'(n - 1), expBlock(n, nb - 1));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stay_idle", 512'(bDone[sel]), 512'd1);
  endtask

  task automatic resetMidFill(input logic [15:0] a);
    sel       = 0;
    baseAddr  = a;
    inputAddr = a;
    ready     = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkIdle("midrst", 16'h0000, 512'd0);
    checkOutput("midrst_index", 512'(bIndex[0]), 512'd0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midrst_idle", 512'(bValid[0]), 512'd0);
  endtask

  initial begin
    rstN      = 1'b0;
    start     = 1'b0;
    ready     = 1'b0;
    sel       = 0;
    baseAddr  = 16'h0000;
    inputAddr = 16'h0000;
    repeat (2) @(negedge clk);
    checkIdle("reset", 16'h0000, 512'd0);
    checkOutput("reset_index", 512'(bIndex[0]), 512'd0);
    rstN = 1'b1;

    applyStimulus(0, 16'h1000, 1'b0, 0);
    checkOutput("n40_b2_s0",  512'(slotOf(gotBlk[2], 0)),  512'h21);
    checkOutput("n40_b2_s8",  512'(slotOf(gotBlk[2], 8)),  512'h8000_0000);
    checkOutput("n40_b2_s14", 512'(slotOf(gotBlk[2], 14)), 512'h0);
    checkOutput("n40_b2_s15", 512'(slotOf(gotBlk[2], 15)), 512'h500);

    applyStimulus(1, 16'hFFFA, 1'b0, 0);
    checkOutput("n14_b0_s13", 512'(slotOf(gotBlk[0], 13)), 512'hE);
    checkOutput("n14_b0_s14", 512'(slotOf(gotBlk[0], 14)), 512'h8000_0000);
    checkOutput("n14_b0_s15", 512'(slotOf(gotBlk[0], 15)), 512'h0);
    checkOutput("n14_b1_s0",  512'(slotOf(gotBlk[1], 0)),  512'h0);
    checkOutput("n14_b1_s15", 512'(slotOf(gotBlk[1], 15)), 512'h1C0);

    applyStimulus(2, 16'h0300, 1'b0, 0);
    checkOutput("n13_s12", 512'(slotOf(gotBlk[0], 12)), 512'hD);
    checkOutput("n13_s13", 512'(slotOf(gotBlk[0], 13)), 512'h8000_0000);
    checkOutput("n13_s14", 512'(slotOf(gotBlk[0], 14)), 512'h0);
    checkOutput("n13_s15", 512'(slotOf(gotBlk[0], 15)), 512'h1A0);

    applyStimulus(0, 16'h2000, 1'b0, 5);

    resetMidFill(16'h4000);
    applyStimulus(0, 16'h4000, 1'b0, 0);

    applyStimulus(0, 16'h2000, 1'b1, 0);
    checkOutput("noise_b0_s0", 512'(slotOf(gotBlk[0], 0)), 512'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
